// File: rtl/vec_pkg.sv
// Shared types and sizing for the vector group sequencer.
package vec_pkg;

    localparam int unsigned LANES   = 8;
    localparam int unsigned MAX_GRP = 32;
    localparam int unsigned VL_MAX  = LANES * MAX_GRP;
    localparam int unsigned ADDR_W  = 5;
    localparam int unsigned CNT_W   = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        ZERO = 2'd2
    } seq_state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] vd;
        logic [ADDR_W-1:0] vs1;
        logic [ADDR_W-1:0] vs2;
    } vreg_addr_t;

endpackage

// File: rtl/vec_tail_mask.sv
// Per-lane write enable for a group beat.
// VEC_GROUP_SEQ_TAIL_MASK_EN: trim the final group to the live tail lanes.
module vec_tail_mask #(
    parameter int unsigned LANES = vec_pkg::LANES,
    parameter int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic [LW-1:0]    vl_lo,
    input  logic             grp_last,
    output logic [LANES-1:0] lane_mask
);

`ifdef VEC_GROUP_SEQ_TAIL_MASK_EN
    // A zero remainder means the last group is full.
    always_comb begin
        lane_mask = '1;
        if (grp_last && (vl_lo != '0)) begin
            for (int i = 0; i < LANES; i++) begin
                lane_mask[i] = (i < int'(vl_lo));
            end
        end
    end
`else
    logic unused_tail;
    assign unused_tail = ^{vl_lo, grp_last};
    assign lane_mask   = '1;
`endif

endmodule

// File: rtl/vec_group_seq.sv
// Splits an accepted vector instruction into LANES-wide group beats for EXE.
// VEC_GROUP_SEQ_TAIL_MASK_EN enables tail masking on the final beat.
module vec_group_seq #(
    parameter int unsigned LANES   = vec_pkg::LANES,
    parameter int unsigned MAX_GRP = vec_pkg::MAX_GRP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [4:0]       issue_vd,
    input  logic [4:0]       issue_vs1,
    input  logic [4:0]       issue_vs2,
    input  logic [31:0]      vlen,
    input  logic             flush,
    input  logic             exe_ready,
    output logic             grp_valid,
    output logic [4:0]       grp_cnt,
    output logic [4:0]       grp_vd,
    output logic [4:0]       grp_vs1,
    output logic [4:0]       grp_vs2,
    output logic [LANES-1:0] lane_mask,
    output logic             grp_last,
    output logic             fe_stall,
    output logic             done
);
    import vec_pkg::*;

    localparam int unsigned LW     = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int unsigned VL_LIM = LANES * MAX_GRP;
    localparam int unsigned VW     = $clog2(VL_LIM + 1);

    seq_state_t        state, state_nx;
    vreg_addr_t        addr_q, addr_nx;
    logic [VW-1:0]     vl_q, vl_nx, vl_in;
    logic [CNT_W-1:0]  cnt_q, cnt_nx, last_idx;
    logic [VW:0]       grp_total;
    logic              done_q, done_nx;
    logic              accept;
    logic [LANES-1:0]  mask_raw;

    assign vl_in     = (vlen > 32'(VL_LIM)) ? VW'(VL_LIM) : vlen[VW-1:0];
    assign grp_total = ({1'b0, vl_q} + (VW+1)'(LANES - 1)) >> LW;
    assign last_idx  = CNT_W'(grp_total - (VW+1)'(1));

    assign issue_ready = (state == IDLE);
    assign accept      = issue_valid & issue_ready & ~flush & ~rst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            addr_q <= '0;
            vl_q   <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            state  <= state_nx;
            addr_q <= addr_nx;
            vl_q   <= vl_nx;
            cnt_q  <= cnt_nx;
            done_q <= done_nx;
        end
    end

    // Flush wins over acceptance and over a final-beat handshake.
    always_comb begin
        state_nx = state;
        addr_nx  = addr_q;
        vl_nx    = vl_q;
        cnt_nx   = cnt_q;
        done_nx  = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    addr_nx  = '{vd: issue_vd, vs1: issue_vs1, vs2: issue_vs2};
                    vl_nx    = vl_in;
                    cnt_nx   = '0;
                    state_nx = (vl_in == '0) ? ZERO : RUN;
                end
            end
            RUN: begin
                if (flush) begin
                    state_nx = IDLE;
                end else if (exe_ready) begin
                    if (grp_last) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt_q + CNT_W'(1);
                    end
                end
            end
            ZERO: begin
                state_nx = IDLE;
                done_nx  = ~flush;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign grp_valid = (state == RUN);
    assign grp_last  = grp_valid & (cnt_q == last_idx);
    assign grp_cnt   = cnt_q;
    assign grp_vd    = addr_q.vd;
    assign grp_vs1   = addr_q.vs1;
    assign grp_vs2   = addr_q.vs2;
    assign lane_mask = grp_valid ? mask_raw : '0;
    assign fe_stall  = (state != IDLE) | accept;
    assign done      = done_q;

    vec_tail_mask #(
        .LANES (LANES),
        .LW    (LW)
    ) u_tail_mask (
        .vl_lo     (vl_q[LW-1:0]),
        .grp_last  (grp_last),
        .lane_mask (mask_raw)
    );

endmodule

// File: tb/tb_vec_group_seq.sv
// Self-checking bench for vec_group_seq against a beat-count reference model.
module tb_vec_group_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_ready;
    logic [4:0]  issue_vd, issue_vs1, issue_vs2;
    logic [31:0] vlen;
    logic        flush;
    logic        exe_ready;
    logic        grp_valid;
    logic [4:0]  grp_cnt, grp_vd, grp_vs1, grp_vs2;
    logic [7:0]  lane_mask;
    logic        grp_last;
    logic        fe_stall;
    logic        done;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    vec_group_seq dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_ready (issue_ready),
        .issue_vd    (issue_vd),
        .issue_vs1   (issue_vs1),
        .issue_vs2   (issue_vs2),
        .vlen        (vlen),
        .flush       (flush),
        .exe_ready   (exe_ready),
        .grp_valid   (grp_valid),
        .grp_cnt     (grp_cnt),
        .grp_vd      (grp_vd),
        .grp_vs1     (grp_vs1),
        .grp_vs2     (grp_vs2),
        .lane_mask   (lane_mask),
        .grp_last    (grp_last),
        .fe_stall    (fe_stall),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Reference model: element count clamps at 256, groups of 8 elements.
    function automatic int model_vl(input int unsigned v);
        return (v > 256) ? 256 : int'(v);
    endfunction

    function automatic int model_beats(input int vl);
        return (vl + 7) / 8;
    endfunction

    function automatic logic [7:0] model_mask(input int vl, input int beat, input int nb);
        logic [7:0] m;
        m = 8'hFF;
`ifdef VEC_GROUP_SEQ_TAIL_MASK_EN
        if (beat == nb - 1 && (vl % 8) != 0) m = 8'((1 << (vl % 8)) - 1);
`endif
        return m;
    endfunction

    // One instruction from acceptance to completion/flush; leaves bench just after a rising edge.
    task automatic run_instr(input int unsigned v, input int stall_beat, input int stall_n,
                             input bit rand_ready, input int flush_beat, input bit flush_hs);
        logic [4:0] vd, vs1, vs2;
        int vl, nb, beat, held;
        bit r, fl;
        vd  = 5'($urandom);
        vs1 = 5'($urandom);
        vs2 = 5'($urandom);
        vl  = model_vl(v);
        nb  = model_beats(vl);
        beat = 0;
        held = 0;

        issue_valid = 1'b1;
        issue_vd = vd; issue_vs1 = vs1; issue_vs2 = vs2;
        vlen = v;
        flush = 1'b0;
        exe_ready = 1'($urandom);
        @(negedge clk);
        chk("accept_ready", 32'(issue_ready), 32'd1);
        chk("accept_stall", 32'(fe_stall), 32'd1);
        chk("accept_valid", 32'(grp_valid), 32'd0);
        chk("accept_done", 32'(done), 32'd0);
        next_cycle();
        issue_valid = 1'b0;
        vlen = $urandom;
        issue_vd = 5'($urandom);

        if (nb == 0) begin
            flush = (flush_beat == 0);
            @(negedge clk);
            chk("zero_valid", 32'(grp_valid), 32'd0);
            chk("zero_done", 32'(done), 32'd0);
            chk("zero_stall", 32'(fe_stall), 32'd1);
            chk("zero_ready", 32'(issue_ready), 32'd0);
            next_cycle();
            flush = 1'b0;
            @(negedge clk);
            chk("zero_done_pulse", 32'(done), 32'(flush_beat != 0));
            chk("zero_idle_ready", 32'(issue_ready), 32'd1);
            chk("zero_idle_valid", 32'(grp_valid), 32'd0);
            next_cycle();
            return;
        end

        for (int guard = 0; guard < 1000; guard++) begin
            if (beat == stall_beat && held < stall_n) begin
                r = 1'b0;
                held++;
            end else if (rand_ready) begin
                r = 1'($urandom);
            end else begin
                r = 1'b1;
            end
            fl = (beat == flush_beat);
            if (fl && flush_hs) r = 1'b1;
            exe_ready = r;
            flush = fl;
            @(negedge clk);
            chk("beat_valid", 32'(grp_valid), 32'd1);
            chk("beat_cnt", 32'(grp_cnt), 32'(beat));
            chk("beat_last", 32'(grp_last), 32'(beat == nb - 1));
            chk("beat_mask", 32'(lane_mask), 32'(model_mask(vl, beat, nb)));
            chk("beat_vd", 32'(grp_vd), 32'(vd));
            chk("beat_vs1", 32'(grp_vs1), 32'(vs1));
            chk("beat_vs2", 32'(grp_vs2), 32'(vs2));
            chk("beat_stall", 32'(fe_stall), 32'd1);
            chk("beat_done", 32'(done), 32'd0);
            chk("beat_ready", 32'(issue_ready), 32'd0);
            next_cycle();
            if (fl) begin
                flush = 1'b0;
                exe_ready = 1'b0;
                @(negedge clk);
                chk("flush_valid", 32'(grp_valid), 32'd0);
                chk("flush_done", 32'(done), 32'd0);
                chk("flush_ready", 32'(issue_ready), 32'd1);
                chk("flush_mask", 32'(lane_mask), 32'd0);
                next_cycle();
                return;
            end
            if (r) begin
                beat++;
                if (beat == nb) begin
                    exe_ready = 1'b0;
                    @(negedge clk);
                    chk("end_done", 32'(done), 32'd1);
                    chk("end_valid", 32'(grp_valid), 32'd0);
                    chk("end_ready", 32'(issue_ready), 32'd1);
                    chk("end_stall", 32'(fe_stall), 32'd0);
                    next_cycle();
                    @(negedge clk);
                    chk("end_done_clear", 32'(done), 32'd0);
                    next_cycle();
                    return;
                end
            end
        end
        chk("beat_timeout", 32'(beat), 32'(nb));
    endtask

    initial begin
        int unsigned v;
        int fb;
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_vd = '0; issue_vs1 = '0; issue_vs2 = '0;
        vlen = '0;
        flush = 1'b0;
        exe_ready = 1'b0;

        @(negedge clk);
        chk("rst_valid", 32'(grp_valid), 32'd0);
        chk("rst_cnt", 32'(grp_cnt), 32'd0);
        chk("rst_mask", 32'(lane_mask), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_stall", 32'(fe_stall), 32'd0);
        chk("rst_vd", 32'(grp_vd), 32'd0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", 32'(issue_ready), 32'd1);
        next_cycle();

        run_instr(20, -1, 0, 1'b0, -1, 1'b0);
        run_instr(16, 1, 2, 1'b0, -1, 1'b0);
        run_instr(0, -1, 0, 1'b0, -1, 1'b0);
        run_instr(1000, -1, 0, 1'b0, -1, 1'b0);
        run_instr(24, -1, 0, 1'b0, 1, 1'b1);
        run_instr(0, -1, 0, 1'b0, 0, 1'b0);
        run_instr(13, -1, 0, 1'b0, 1, 1'b1);

        // Flush beats a simultaneous issue.
        issue_valid = 1'b1;
        vlen = 40;
        flush = 1'b1;
        @(negedge clk);
        chk("flushacc_stall", 32'(fe_stall), 32'd0);
        next_cycle();
        issue_valid = 1'b0;
        flush = 1'b0;
        @(negedge clk);
        chk("flushacc_valid", 32'(grp_valid), 32'd0);
        chk("flushacc_ready", 32'(issue_ready), 32'd1);
        chk("flushacc_stall2", 32'(fe_stall), 32'd0);
        next_cycle();

        // Reset in the middle of a run.
        issue_valid = 1'b1;
        vlen = 100;
        exe_ready = 1'b1;
        next_cycle();
        issue_valid = 1'b0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        chk("mid_valid", 32'(grp_valid), 32'd1);
        chk("mid_cnt", 32'(grp_cnt), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(grp_valid), 32'd0);
        chk("midrst_cnt", 32'(grp_cnt), 32'd0);
        chk("midrst_last", 32'(grp_last), 32'd0);
        chk("midrst_mask", 32'(lane_mask), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_stall", 32'(fe_stall), 32'd0);
        chk("midrst_vs1", 32'(grp_vs1), 32'd0);
        next_cycle();
        rst = 1'b0;
        exe_ready = 1'b0;
        run_instr(9, -1, 0, 1'b0, -1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            case ($urandom % 4)
                0: v = $urandom_range(0, 16);
                1: v = $urandom_range(0, 256);
                2: v = $urandom_range(257, 5000);
                default: v = $urandom;
            endcase
            fb = ($urandom % 4 == 0) ? int'($urandom_range(0, 8)) : -1;
            run_instr(v, -1, 0, 1'b1, fb, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/vec_group_seq.md
VEC_GROUP_SEQ -- requirements
Module: vec_group_seq

Interface
REQ-001 SHALL have parameter LANES, default 8, lanes per element group.
REQ-002 SHALL have parameter MAX_GRP, default 32, maximum groups per instruction.
REQ-003 SHALL have port clk  in  1  single clock, all flops rising edge.
REQ-004 SHALL have port rst  in  1  asynchronous, active-high reset.
REQ-005 SHALL have port issue_valid  in  1  decoded vector instruction present.
REQ-006 SHALL have port issue_ready  out  1  sequencer accepts an instruction.
REQ-007 SHALL have port issue_vd / issue_vs1 / issue_vs2  in  5 each  vector register addresses.
REQ-008 SHALL have port vlen  in  32  element count, sampled at acceptance only.
REQ-009 SHALL have port flush  in  1  taken-branch squash.
REQ-010 SHALL have port exe_ready  in  1  EXE accepts a group this cycle.
REQ-011 SHALL have port grp_valid  out  1  group beat presented to EXE.
REQ-012 SHALL have port grp_cnt  out  5  group index, the cnt fed to ID_EXE.
REQ-013 SHALL have port grp_vd / grp_vs1 / grp_vs2  out  5 each  latched addresses.
REQ-014 SHALL have port lane_mask  out  LANES  per-lane write enable.
REQ-015 SHALL have port grp_last  out  1  current beat is final group.
REQ-016 SHALL have port fe_stall  out  1  hold PC and IF/ID.
REQ-017 SHALL have port done  out  1  one-cycle completion pulse.

Function
REQ-018 SHALL implement states IDLE, RUN, ZERO.
REQ-019 SHALL drive issue_ready=1 only in IDLE; acceptance = issue_valid & issue_ready & !flush.
REQ-020 SHALL, on acceptance, latch addresses and vl = min(vlen, LANES*MAX_GRP) = min(vlen,256); grp_cnt <= 0.
REQ-021 SHALL go IDLE->RUN on acceptance with vl>0; IDLE->ZERO with vl==0.
REQ-022 SHALL assert grp_valid=1 exactly in RUN; first beat one cycle after acceptance.
REQ-023 SHALL advance grp_cnt by 1 on grp_valid & exe_ready; hold all beat outputs otherwise.
REQ-024 SHALL compute last index = ((vl+7)>>3)-1; grp_last = RUN & (grp_cnt==last index).
REQ-025 SHALL go RUN->IDLE on grp_valid & exe_ready & grp_last; done=1 the following cycle.
REQ-026 SHALL go ZERO->IDLE after one cycle with done=1 in that next cycle; no beat issued.
REQ-027 SHALL drive fe_stall = (state!=IDLE) | acceptance.
REQ-028 SHALL, on flush in RUN or ZERO, go IDLE next cycle, drop grp_valid, suppress done.
REQ-029 SHALL give flush priority over acceptance and over a simultaneous last-beat handshake (no done).
REQ-030 SHALL ignore vlen changes after acceptance.
REQ-031 SHALL drive lane_mask=0 when grp_valid=0.

Reset
REQ-032 SHALL, on rst, asynchronously clear: state=IDLE, grp_cnt=0, grp_valid=0, grp_last=0, lane_mask=0, done=0, fe_stall=0, latched addresses=0, vl=0.
REQ-033 SHALL abandon any in-flight instruction on rst with no done pulse; issue_ready=1 first cycle after release.

Configuration
REQ-034 SHALL honour macro VEC_GROUP_SEQ_TAIL_MASK_EN.
REQ-035 SHALL, with it defined, drive lane_mask on the last beat = (vl[2:0]==0) ? all ones : (1<<vl[2:0])-1; non-last beats all ones.
REQ-036 SHALL, without it, drive lane_mask all ones on every valid beat (tail lanes written).

Structure
REQ-037 SHALL take LANES, MAX_GRP, VL_MAX=256 and the state enum from shared package vec_pkg.
REQ-038 SHALL place mask generation in sub-module vec_tail_mask (vl[2:0], grp_last -> lane_mask).

Verification
REQ-039 SHALL cover vlen=20, exe_ready=1 -> 3 beats, grp_cnt 0,1,2; masks FF,FF,0F (macro) or FF×3; done cycle after beat 2.
REQ-040 SHALL cover vlen=16, exe_ready low 2 cycles on beat 1 -> beat 1 held 3 cycles, grp_cnt stays 1, fe_stall=1 throughout.
REQ-041 SHALL cover vlen=0 -> no grp_valid, done exactly 2 cycles after acceptance.
REQ-042 SHALL cover vlen=1000 -> clamped, 32 beats, last grp_cnt=31, last mask FF.
REQ-043 SHALL cover flush coincident with beat 1 handshake of vlen=24 -> IDLE next cycle, no beat 2, no done.
REQ-044 SHALL cover rst asserted mid-RUN -> all outputs zero immediately; new issue accepted the cycle after release.
